// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: hazard FSM states, register-zero constant,
// ID_EX control field widths and the MemRead bit position in the mem field.
// Ports: none (package only).
package cpu_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ID_EX control field widths
  localparam int WB_W = 2;
  localparam int MEM_W = 2;
  localparam int EX_W = 4;

  // MemRead position inside the ID_EX mem control field
  localparam int MEM_READ_BIT = 1;

endpackage

// File: rtl/load_use_cmp.sv
// Load-use comparator: flags when the load in ID_EX writes a register that
// the IF_ID instruction reads. Pure combinational, zero latency.
// Ports: memread, ld_rt (load destination), rs/rt/uses_rt (IF_ID sources) -> hazard.
module load_use_cmp
  import cpu_pkg::*;
(
  input  logic       memread,
  input  logic [4:0] ld_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ld_rt == rs);
  // rt only matters when the decoded instruction actually sources it
  assign rt_match = uses_rt && (ld_rt == rt);
  // $zero is hardwired, so a load into it can never feed a consumer
  assign hazard   = memread && (ld_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector and stall/flush controller for the 5-stage pipeline.
// Outputs are combinational from inputs, FSM state and hold counter.
// Ports: clk_i/rst_i, ID_EX load info, IF_ID sources, branch_taken_i ->
//        pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, stall_cnt_o.
module hazard_detect_unit
  import cpu_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rtaddr_i,
  input  logic [4:0]       ifid_rsaddr_i,
  input  logic [4:0]       ifid_rtaddr_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int HC_W = $clog2(LOAD_STALL + 1);
  // The first stall cycle is spent in RUN, so HOLD covers the remaining
  // LOAD_STALL-1 cycles, counting down to zero.
  localparam logic [HC_W-1:0] HOLD_INIT =
    (LOAD_STALL > 1) ? HC_W'(LOAD_STALL - 2) : '0;

  hdu_state_e      state;
  logic [HC_W-1:0] cnt;
  logic            hazard;
  logic            stall;

  load_use_cmp u_cmp (
    .memread (idex_memread_i),
    .ld_rt   (idex_rtaddr_i),
    .rs      (ifid_rsaddr_i),
    .rt      (ifid_rtaddr_i),
    .uses_rt (ifid_uses_rt_i),
    .hazard  (hazard)
  );

  // HOLD ignores the comparator: ID_EX already carries a bubble
  assign stall = ((state == RUN) && hazard) || (state == HOLD);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          // With a single bubble the load moves on and the hazard clears
          if (hazard && (LOAD_STALL > 1)) begin
            cnt   <= HOLD_INIT;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter for performance debug
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b1;
    ifid_flush_o  = 1'b0;
    if (rst_i && !stall) begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_bubble_o = 1'b0;
      // A stall defers the branch; it is re-evaluated once the stall ends
      ifid_flush_o  = branch_taken_i;
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;

  logic       clk;
  logic       rst;
  logic       memread;
  logic [4:0] ld_rt;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       br;

  logic [3:0]  ctl [3];
  logic [15:0] cnt [3];
  logic [15:0] c1, c3;
  logic [3:0]  c4;

  int passed = 0;
  int total  = 0;

  // reference model: remaining forced stall cycles and stall counts
  int left [3];
  int scnt [3];
  int lst  [3] = '{1, 3, 4};
  int cmax [3] = '{65535, 65535, 15};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_detect_unit #(.LOAD_STALL(1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
    .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .pc_write_o(ctl[0][3]), .ifid_write_o(ctl[0][2]),
    .idex_bubble_o(ctl[0][1]), .ifid_flush_o(ctl[0][0]), .stall_cnt_o(c1));

  hazard_detect_unit #(.LOAD_STALL(3), .CNT_W(16)) dut3 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
    .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .pc_write_o(ctl[1][3]), .ifid_write_o(ctl[1][2]),
    .idex_bubble_o(ctl[1][1]), .ifid_flush_o(ctl[1][0]), .stall_cnt_o(c3));

  hazard_detect_unit #(.LOAD_STALL(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rtaddr_i(ld_rt),
    .ifid_rsaddr_i(rs), .ifid_rtaddr_i(rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .pc_write_o(ctl[2][3]), .ifid_write_o(ctl[2][2]),
    .idex_bubble_o(ctl[2][1]), .ifid_flush_o(ctl[2][0]), .stall_cnt_o(c4));

  assign cnt[0] = c1;
  assign cnt[1] = c3;
  assign cnt[2] = {12'd0, c4};

  typedef struct {
    logic       memread;
    logic [4:0] ld_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic [3:0] exp_ctl;   // {pc_write, ifid_write, bubble, flush} for LOAD_STALL=1
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  function automatic bit ref_hazard();
    if (!memread || ld_rt == 0) return 1'b0;
    return (ld_rt == rs) || (uses_rt && ld_rt == rt);
  endfunction

  function automatic logic [3:0] ref_ctl(input int i);
    if (!rst) return 4'b0010;
    if (left[i] > 0 || ref_hazard()) return 4'b0010;
    return {3'b110, br};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      left[i] = 0;
      scnt[i] = 0;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_ctl[L=%0d]", lst[i]), int'(ctl[i]), int'(ref_ctl(i)));
      chk($sformatf("model_cnt[L=%0d]", lst[i]), int'(cnt[i]), scnt[i]);
    end
  endtask

  // advance the model by one rising edge using the current inputs
  task automatic model_next();
    bit h;
    h = ref_hazard();
    if (!rst) return;
    for (int i = 0; i < 3; i++) begin
      if (left[i] > 0 || h) begin
        if (scnt[i] < cmax[i]) scnt[i]++;
      end
      if (left[i] > 0) left[i]--;
      else if (h) left[i] = lst[i] - 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic u, input logic b);
    memread = m; ld_rt = d; rs = s; rt = t; uses_rt = u; br = b;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      settle();
      adv();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int base1, base3;

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    model_reset();

    vecs[0] = '{1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 4'b0010, "lw_rs_match"};
    vecs[1] = '{1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 4'b1100, "no_memread"};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b1100, "lw_to_zero"};
    vecs[3] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 4'b1100, "rt_unused"};
    vecs[4] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 4'b0010, "rt_used"};
    vecs[5] = '{1'b0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b1, 4'b1101, "branch_flush"};
    vecs[6] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 4'b0010, "hazard_beats_branch"};
    vecs[7] = '{1'b1, 5'd7, 5'd3, 5'd9, 1'b1, 1'b1, 4'b1101, "no_match_branch"};

    // reset state: forced outputs and zero counters while held
    #2;
    chk("reset_ctl", int'(ctl[1]), 4'b0010);
    chk("reset_cnt", int'(cnt[1]), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // table vectors, idle cycle after each so the next starts from RUN
    foreach (vecs[v]) begin
      drive(vecs[v].memread, vecs[v].ld_rt, vecs[v].rs, vecs[v].rt,
            vecs[v].uses_rt, vecs[v].br);
      settle();
      chk(vecs[v].name, int'(ctl[0]), int'(vecs[v].exp_ctl));
      adv();
      idle_cycles(4);
    end

    // single load-use with LOAD_STALL 1 and 3
    apply_reset();
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("l1_ctl_cyc%0d", k), int'(ctl[0]), (k == 0) ? 4'b0010 : 4'b1100);
      chk($sformatf("l3_ctl_cyc%0d", k), int'(ctl[1]), (k < 3) ? 4'b0010 : 4'b1100);
      adv();
      if (k == 0) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    end
    chk("l1_stall_cnt", int'(cnt[0]), 1);
    chk("l3_stall_cnt", int'(cnt[1]), 3);

    // HOLD ignores a branch; reset asserted mid-HOLD on the LOAD_STALL=4 unit
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    settle();
    adv();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    settle();
    chk("hold_ignores_branch", int'(ctl[2]), 4'b0010);
    adv();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_hold_ctl", int'(ctl[2]), 4'b0010);
    chk("rst_mid_hold_cnt", int'(cnt[2]), 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle();
    adv();
    rst = 1'b1;
    settle();
    chk("after_rst_idle", int'(ctl[2]), 4'b1100);
    adv();

    // saturation of the 4-bit counter under continuous hazard
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      settle();
      adv();
    end
    settle();
    chk("cnt4_saturated", int'(cnt[2]), 15);
    adv();

    // randomized traffic against the model
    base1 = 0;
    idle_cycles(4);
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      settle();
      adv();
    end
    idle_cycles(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
